// File: rtl/clock_pkg.sv
// clock_pkg
// Shared field widths, legal maxima and a range-check helper for the
// time-of-day datapath. The time-setting and alarm-compare stages import
// this package as well, so every stage agrees on the field encodings.
package clock_pkg;

    localparam int H_W = 5;
    localparam int M_W = 6;
    localparam int S_W = 6;

    localparam logic [H_W-1:0] HOURS_MAX = 5'd23;
    localparam logic [M_W-1:0] MIN_MAX   = 6'd59;
    localparam logic [S_W-1:0] SEC_MAX   = 6'd59;

    // True when every field lies in its legal range. Comparisons are made
    // at the field widths, so codes 24..31 and 60..63 are rejected.
    function automatic logic time_is_valid(
        input logic [H_W-1:0] h,
        input logic [M_W-1:0] m,
        input logic [S_W-1:0] s
    );
        return (h <= HOURS_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// time_of_day_counter_if
// Bundles the control, load and time/strobe signals of the time-of-day
// counter.
//   master : drives run/load/H_IN/M_IN/S_IN, observes time and strobes
//   slave  : the counter itself (inverse directions)
interface time_of_day_counter_if;
    import clock_pkg::*;

    logic           run;
    logic           load;
    logic [H_W-1:0] H_IN;
    logic [M_W-1:0] M_IN;
    logic [S_W-1:0] S_IN;
    logic [H_W-1:0] H_OUT;
    logic [M_W-1:0] M_OUT;
    logic [S_W-1:0] S_OUT;
    logic           sec_pulse;
    logic           midnight;
    logic           load_err;

    modport master (
        output run, load, H_IN, M_IN, S_IN,
        input  H_OUT, M_OUT, S_OUT, sec_pulse, midnight, load_err
    );

    modport slave (
        input  run, load, H_IN, M_IN, S_IN,
        output H_OUT, M_OUT, S_OUT, sec_pulse, midnight, load_err
    );

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides clk down to TICK_HZ. The counter runs 0..CLK_HZ/TICK_HZ-1 while
// en is high and wraps; tick is asserted combinationally during the wrap
// cycle so the consumer can act on the very same edge.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   en    : count enable; the counter holds while low
//   clr   : synchronous clear to 0, takes priority over counting
//   tick  : high in the cycle whose edge wraps the counter
module tick_prescaler #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    // Keep at least one bit so a divide-by-one build still elaborates.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign tick = en && (cnt_reg == TERM);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = tick ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter
// Free-running 24-hour clock. A prescaler produces a once-per-second tick;
// on that edge the seconds/minutes/hours carry chain advances. A one-cycle
// load replaces the time when every field is legal, otherwise it is
// rejected with a load_err pulse.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : slave side of time_of_day_counter_if
//           (run, load, H_IN/M_IN/S_IN in; H_OUT/M_OUT/S_OUT,
//            sec_pulse, midnight, load_err out)
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    time_of_day_counter_if.slave   bus
);

    logic [H_W-1:0] h_reg, h_next;
    logic [M_W-1:0] m_reg, m_next;
    logic [S_W-1:0] s_reg, s_next;
    logic           sec_pulse_reg, sec_pulse_next;
    logic           midnight_reg, midnight_next;
    logic           load_err_reg, load_err_next;

    logic           tick;
    logic           load_valid;

    assign load_valid = bus.load && time_is_valid(bus.H_IN, bus.M_IN, bus.S_IN);

    // Only an accepted load restarts the second; a rejected load leaves the
    // prescaler phase alone so the running second is not stretched.
    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (bus.run),
        .clr   (load_valid),
        .tick  (tick)
    );

    always_comb begin
        h_next         = h_reg;
        m_next         = m_reg;
        s_next         = s_reg;
        sec_pulse_next = 1'b0;
        midnight_next  = 1'b0;
        load_err_next  = 1'b0;

        // A load in the tick cycle wins and the tick is simply dropped.
        if (bus.load) begin
            if (load_valid) begin
                h_next = bus.H_IN;
                m_next = bus.M_IN;
                s_next = bus.S_IN;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (tick) begin
            sec_pulse_next = 1'b1;
            if (s_reg == SEC_MAX) begin
                s_next = '0;
                if (m_reg == MIN_MAX) begin
                    m_next = '0;
                    if (h_reg == HOURS_MAX) begin
                        h_next        = '0;
                        midnight_next = 1'b1;
                    end else begin
                        h_next = h_reg + 1'b1;
                    end
                end else begin
                    m_next = m_reg + 1'b1;
                end
            end else begin
                s_next = s_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_reg         <= '0;
            m_reg         <= '0;
            s_reg         <= '0;
            sec_pulse_reg <= 1'b0;
            midnight_reg  <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            h_reg         <= h_next;
            m_reg         <= m_next;
            s_reg         <= s_next;
            sec_pulse_reg <= sec_pulse_next;
            midnight_reg  <= midnight_next;
            load_err_reg  <= load_err_next;
        end
    end

    assign bus.H_OUT     = h_reg;
    assign bus.M_OUT     = m_reg;
    assign bus.S_OUT     = s_reg;
    assign bus.sec_pulse = sec_pulse_reg;
    assign bus.midnight  = midnight_reg;
    assign bus.load_err  = load_err_reg;

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter
// Directed bench for time_of_day_counter with CLK_HZ=10 (1 s = 10 cycles).
// A seconds-of-day reference model is stepped on every rising edge and a
// compare process checks all outputs on every falling edge; hand-computed
// literal checks pin the model at the interesting points.
module tb_time_of_day_counter;

    localparam int CLK_HZ = 10;
    localparam int DIV    = CLK_HZ;
    localparam int DAY    = 86400;

    logic clk;
    logic reset;

    time_of_day_counter_if bus();

    time_of_day_counter #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time as seconds since midnight plus the cycle phase
    // within the current second.
    int m_tod   = 0;
    int m_phase = 0;
    bit m_sec   = 1'b0;
    bit m_mid   = 1'b0;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_sec = 1'b0;
        m_mid = 1'b0;
        m_err = 1'b0;
        if (!reset) begin
            m_tod   = 0;
            m_phase = 0;
        end else if (bus.load) begin
            if (bus.H_IN < 24 && bus.M_IN < 60 && bus.S_IN < 60) begin
                m_tod   = int'(bus.H_IN) * 3600 + int'(bus.M_IN) * 60 + int'(bus.S_IN);
                m_phase = 0;
            end else begin
                m_err = 1'b1;
                if (bus.run) m_phase = (m_phase + 1) % DIV;
            end
        end else if (bus.run) begin
            if (m_phase == DIV - 1) begin
                m_sec = 1'b1;
                m_mid = (m_tod == DAY - 1);
                m_tod = (m_tod + 1) % DAY;
            end
            m_phase = (m_phase + 1) % DIV;
        end
        m_valid = 1'b1;
    endtask

    // One clock: model follows the edge, then return at the falling edge
    // where inputs may safely change.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        bus.load = 1'b1;
        bus.H_IN = 5'(h);
        bus.M_IN = 6'(m);
        bus.S_IN = 6'(s);
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic lit_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".H"}, 32'(bus.H_OUT), 32'(h));
        chk({tag, ".M"}, 32'(bus.M_OUT), 32'(m));
        chk({tag, ".S"}, 32'(bus.S_OUT), 32'(s));
        $display("check %s: %02d:%02d:%02d sec=%0b mid=%0b err=%0b", tag,
                 bus.H_OUT, bus.M_OUT, bus.S_OUT, bus.sec_pulse, bus.midnight, bus.load_err);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("H_OUT", 32'(bus.H_OUT), 32'(m_tod / 3600));
            chk("M_OUT", 32'(bus.M_OUT), 32'((m_tod / 60) % 60));
            chk("S_OUT", 32'(bus.S_OUT), 32'(m_tod % 60));
            chk("sec_pulse", 32'(bus.sec_pulse), 32'(m_sec));
            chk("midnight", 32'(bus.midnight), 32'(m_mid));
            chk("load_err", 32'(bus.load_err), 32'(m_err));
        end
    end

    initial begin
        reset    = 1'b0;
        bus.run  = 1'b0;
        bus.load = 1'b1;
        bus.H_IN = 5'd5;
        bus.M_IN = 6'd0;
        bus.S_IN = 6'd0;

        // Reset held with a load pending: load is lost.
        repeat (3) cycle();
        lit_time("reset", 0, 0, 0);
        chk("reset.sec", 32'(bus.sec_pulse), 32'd0);
        chk("reset.mid", 32'(bus.midnight), 32'd0);
        chk("reset.err", 32'(bus.load_err), 32'd0);

        // First second after release takes exactly 10 edges.
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.run  = 1'b1;
        repeat (9) cycle();
        lit_time("first_s_pre", 0, 0, 0);
        cycle();
        lit_time("first_s", 0, 0, 1);
        chk("first_s.sec", 32'(bus.sec_pulse), 32'd1);
        cycle();
        chk("first_s.sec_drop", 32'(bus.sec_pulse), 32'd0);

        // Carry chain.
        do_load(0, 58, 59);
        lit_time("load_005859", 0, 58, 59);
        repeat (10) cycle();
        lit_time("carry_min", 0, 59, 0);
        do_load(0, 59, 59);
        repeat (10) cycle();
        lit_time("carry_hour", 1, 0, 0);

        // Midnight rollover.
        do_load(23, 59, 58);
        repeat (10) cycle();
        lit_time("pre_mid", 23, 59, 59);
        chk("pre_mid.mid", 32'(bus.midnight), 32'd0);
        repeat (10) cycle();
        lit_time("midnight", 0, 0, 0);
        chk("midnight.mid", 32'(bus.midnight), 32'd1);
        chk("midnight.sec", 32'(bus.sec_pulse), 32'd1);
        cycle();
        chk("midnight.mid_drop", 32'(bus.midnight), 32'd0);

        // Invalid loads keep time and prescaler phase.
        do_load(12, 30, 15);
        repeat (4) cycle();
        do_load(24, 30, 15);
        lit_time("bad_hour", 12, 30, 15);
        chk("bad_hour.err", 32'(bus.load_err), 32'd1);
        cycle();
        chk("bad_hour.err_drop", 32'(bus.load_err), 32'd0);
        repeat (3) cycle();
        lit_time("phase_kept_pre", 12, 30, 15);
        cycle();
        lit_time("phase_kept", 12, 30, 16);
        do_load(12, 30, 60);
        lit_time("bad_sec", 12, 30, 16);
        chk("bad_sec.err", 32'(bus.load_err), 32'd1);

        // Valid load in the tick cycle wins.
        do_load(7, 59, 59);
        repeat (9) cycle();
        lit_time("collide_pre", 7, 59, 59);
        do_load(8, 0, 0);
        lit_time("collide", 8, 0, 0);
        chk("collide.sec", 32'(bus.sec_pulse), 32'd0);
        repeat (9) cycle();
        lit_time("collide_wait", 8, 0, 0);
        cycle();
        lit_time("collide_tick", 8, 0, 1);

        // Pause mid-second, then finish the remaining 7 cycles.
        do_load(10, 0, 0);
        repeat (3) cycle();
        bus.run = 1'b0;
        repeat (25) cycle();
        lit_time("paused", 10, 0, 0);
        bus.run = 1'b1;
        repeat (6) cycle();
        lit_time("resume_pre", 10, 0, 0);
        cycle();
        lit_time("resume_tick", 10, 0, 1);

        // Load while paused is accepted and stays frozen.
        bus.run = 1'b0;
        do_load(11, 11, 11);
        repeat (12) cycle();
        lit_time("paused_load", 11, 11, 11);
        bus.run = 1'b1;

        // Reset mid-count with a load strobe.
        repeat (4) cycle();
        reset    = 1'b0;
        bus.load = 1'b1;
        bus.H_IN = 5'd3;
        bus.M_IN = 6'd3;
        bus.S_IN = 6'd3;
        cycle();
        lit_time("reset_mid", 0, 0, 0);
        reset    = 1'b1;
        bus.load = 1'b0;
        repeat (10) cycle();
        lit_time("after_reset", 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Free-running 24-hour time-of-day counter. It divides the board clock to a 1 Hz tick and maintains the hours, minutes and seconds registers.
- Drives H_OUT/M_OUT/S_OUT directly into the alarm comparator stage (and the display path).
- Accepts a one-cycle load of a user-set time from the time-setting stage.
- Provides an enable for pause, plus second and midnight strobes for downstream consumers.

Parameters:
- CLK_HZ, 100000000, input clock frequency; the prescaler terminal count is CLK_HZ-1.
- TICK_HZ, 1, counting rate; the bench overrides CLK_HZ=10 so that 1 s equals 10 cycles.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- run  in  1  1 = time advances; 0 = prescaler and time frozen (outputs held).
- load  in  1  one-cycle strobe; captures H_IN/M_IN/S_IN.
- H_IN  in  5  hours to load, legal range 0..23.
- M_IN  in  6  minutes to load, legal range 0..59.
- S_IN  in  6  seconds to load, legal range 0..59.
- H_OUT  out  5  current hours, 0..23.
- M_OUT  out  6  current minutes, 0..59.
- S_OUT  out  6  current seconds, 0..59.
- sec_pulse  out  1  one-cycle high on the clock edge where S_OUT advances.
- midnight  out  1  one-cycle high on the edge where time rolls 23:59:59 -> 00:00:00.
- load_err  out  1  one-cycle high when a load is rejected.

Behaviour:
- Reset (reset==0 at posedge):
  - H_OUT/M_OUT/S_OUT = 0.
  - Prescaler = 0.
  - sec_pulse, midnight, load_err = 0.
  - Reset overrides load and run.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1 while run=1, then wraps to 0.
  - The wrap cycle generates an internal tick.
  - Holds its value while run=0.
- Time update on tick, in the same edge as the tick (no extra latency):
  - S_OUT increments; 59 wraps to 0 with carry to M_OUT.
  - M_OUT increments on carry; 59 wraps to 0 with carry to H_OUT.
  - H_OUT increments on carry; 23 wraps to 0.
- sec_pulse:
  - Registered.
  - High in the cycle after the edge where the counters changed, i.e. aligned with the new S_OUT value.
- midnight:
  - Registered, same alignment as sec_pulse.
  - Asserted together with sec_pulse on the 23:59:59 -> 00:00:00 wrap only.
- Load, valid case (H_IN<=23, M_IN<=59, S_IN<=59):
  - Outputs take H_IN/M_IN/S_IN at the next edge.
  - Prescaler cleared to 0, so the first tick after a load occurs a full second later.
  - No sec_pulse or midnight for a loaded value.
- Load, invalid case (any field out of range):
  - Time and prescaler unchanged.
  - load_err high for exactly one cycle.
- Load and tick in the same cycle: load wins (valid or not). The tick is discarded and the prescaler is cleared only if the load was valid.
- Load with run=0 is accepted; time stays frozen at the loaded value.
- Reset mid-count or mid-load: all state returns to reset values at that edge. A load strobe during reset is lost.
- Arithmetic: all comparisons use the port widths. Values 24..31 / 60..63 can never appear on the outputs.

Decomposition:
- Shared package clock_pkg with:
  - HOURS_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - Field widths H_W=5, M_W=6, S_W=6.
  - These are also used by the time-setting and alarm-compare stages.
- One sub-module: tick_prescaler.
  - Parameters CLK_HZ and TICK_HZ.
  - Ports: clk, reset, en, clr, tick.
- Time registers, carry chain and load validation live in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with load=1, H_IN=5 -> outputs 00:00:00, all strobes 0. Release with run=1 -> S_OUT=1 exactly 10 cycles later (CLK_HZ=10), with sec_pulse aligned.
- Carry chain: load 00:58:59, run -> after 1 tick reads 00:59:00; load 00:59:59 -> after 1 tick reads 01:00:00.
- Midnight: load 23:59:58 -> next tick 23:59:59 with midnight=0, following tick 00:00:00 with midnight=1 and sec_pulse=1 for one cycle.
- Invalid load: at 12:30:15 strobe load with H_IN=24 (also a case with S_IN=60) -> time unchanged, load_err pulses exactly one cycle, prescaler phase preserved.
- Load/tick collision: assert valid load 08:00:00 on the tick cycle -> outputs 08:00:00, no sec_pulse, next S_OUT=1 exactly 10 cycles later.
- Pause: run=0 for 25 cycles mid-second -> outputs and prescaler frozen. Resume -> remaining cycles of that second complete before the tick.
